load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 55 +++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 size codes, completion error codes and request classification.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_ILLEGAL  = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_e;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;
   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;

   // Illegal encodings take precedence over misalignment.
   function automatic err_e classify(input logic       wr,
                                     input logic       rd,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
      err_e err;
      err = ERR_OK;
      if (wr && rd)
         err = ERR_ILLEGAL;
      else if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
         err = ERR_ILLEGAL;
      else if (wr && f3 > 3'd2)
         err = ERR_ILLEGAL;
      else if ((wr || rd) && f3[1:0] == 2'b01 && off[0])
         err = ERR_MISALIGN;
      else if ((wr || rd) && f3[1:0] == 2'b10 && off != 2'b00)
         err = ERR_MISALIGN;
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores (byte enables, replicated data) and load
// extraction with sign/zero extension. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  byte_off,
   input  logic [2:0]  funct3,
   input  logic        is_store,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {byte_off, 3'b000};

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      be    = 4'b0000;
      wdata = 32'h0;
      if (is_store) begin
         unique case (funct3)
            SB: begin
               be    = 4'b0001 << byte_off;
               wdata = {4{store_data[7:0]}};
            end
            SH: begin
               be    = 4'b0011 << byte_off;
               wdata = {2{store_data[15:0]}};
            end
            SW: begin
               be    = 4'b1111;
               wdata = store_data;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      load_data = 32'h0;
      unique case (funct3)
         LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
         LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
         LW:      load_data = rdata;
         LBU:     load_data = {24'h0, shifted[7:0]};
         LHU:     load_data = {16'h0, shifted[15:0]};
         default: load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one pipeline request, issues a
// word-addressed memory access with an ack timeout, and returns one response.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_wr,
   input  logic        mem_read,
   input  logic [11:0] addr,
   input  logic [31:0] write_data,
   input  logic [2:0]  funct3,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [1:0]  resp_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [9:0]  dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [11:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   err_e              resp_err_q, resp_err_d;
   logic [31:0]       resp_data_q, resp_data_d;
   logic              req_ready_q, req_ready_d;
   logic              dmem_req_q, dmem_req_d;
   logic              resp_valid_q, resp_valid_d;

   err_e              req_err;
   logic [31:0]       load_data;

   assign req_err = classify(mem_wr, mem_read, funct3, addr[1:0]);

   lsu_align u_align (
      .byte_off   (addr_q[1:0]),
      .funct3     (funct3_q),
      .is_store   (wr_q & ~rd_q),
      .store_data (wdata_q),
      .rdata      (dmem_rdata),
      .be         (dmem_be),
      .wdata      (dmem_wdata),
      .load_data  (load_data)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      funct3_d    = funct3_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      resp_err_d  = resp_err_q;
      resp_data_d = resp_data_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d      = addr;
               wdata_d     = write_data;
               funct3_d    = funct3;
               wr_d        = mem_wr;
               rd_d        = mem_read;
               cnt_d       = '0;
               resp_err_d  = req_err;
               resp_data_d = 32'h0;
               // Faulty requests and no-op requests never touch memory.
               if (req_err != ERR_OK || !(mem_wr || mem_read))
                  state_d = RESP;
               else
                  state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != CNT_W'(TIMEOUT))
               cnt_d = cnt_q + 1'b1;
            if (dmem_ack) begin
               state_d     = RESP;
               resp_data_d = rd_q ? load_data : 32'h0;
            end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
               state_d     = RESP;
               resp_err_d  = ERR_TIMEOUT;
               resp_data_d = 32'h0;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      req_ready_d  = (state_d == IDLE);
      dmem_req_d   = (state_d == ACCESS);
      resp_valid_d = (state_d == RESP);
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         wr_q         <= 1'b0;
         rd_q         <= 1'b0;
         cnt_q        <= '0;
         resp_err_q   <= ERR_OK;
         resp_data_q  <= '0;
         req_ready_q  <= 1'b0;
         dmem_req_q   <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         funct3_q     <= funct3_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
         req_ready_q  <= req_ready_d;
         dmem_req_q   <= dmem_req_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = wr_q;
   assign dmem_addr  = addr_q[11:2];

endmodule
